// File: rtl/ifmap_tile_radr_gen_if.sv
// Address stream between the ifmap read-address generator and the buffer read port.
// The master drives adr/adr_pad/adr_valid, and the slave returns adr_ready.
interface ifmap_tile_radr_gen_if #(
    parameter int BANK_ADDR_WIDTH = 8
) ();
    logic                       adr_valid;
    logic                       adr_ready;
    logic [BANK_ADDR_WIDTH-1:0] adr;
    logic                       adr_pad;

    modport master (
        output adr_valid,
        output adr,
        output adr_pad,
        input  adr_ready
    );

    modport slave (
        input  adr_valid,
        input  adr,
        input  adr_pad,
        output adr_ready
    );
endinterface

// File: rtl/ifmap_tile_radr_gen.sv
// Read-address generator for the ifmap double buffer. It walks the (ox0, oy0, fx, fy, ic1)
// window with stride, dilation and zero-padding detection, and emits a valid/ready address stream.
module ifmap_tile_radr_gen #(
    parameter int BANK_ADDR_WIDTH = 8,
    parameter int CFG_W           = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 config_en,
    input  logic [10*CFG_W-1:0]  config_data,
    input  logic                 start,
    ifmap_tile_radr_gen_if.master adr_if,
    output logic                 busy,
    output logic                 done
);

    localparam int XW = 2*CFG_W + 2;
    localparam int AW = BANK_ADDR_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [10*CFG_W-1:0]  cfg_q, cfg_d;
    logic [CFG_W-1:0]     ox_q, ox_d;
    logic [CFG_W-1:0]     oy_q, oy_d;
    logic [CFG_W-1:0]     fx_q, fx_d;
    logic [CFG_W-1:0]     fy_q, fy_d;
    logic [CFG_W-1:0]     ic_q, ic_d;
    logic                 done_q, done_d;

    logic [CFG_W-1:0] ox0_c, oy0_c, fx_c, fy_c, stride_c, dil_c, pad_c, ix0_c, iy0_c, ic1_c;
    logic [CFG_W-1:0] ox_last, oy_last, fx_last, fy_last, ic_last;
    logic [CFG_W-1:0] stride_e, dil_e;
    logic [XW-1:0]    x_u, y_u;
    logic             is_pad;
    logic             last_elem;
    logic [AW-1:0]    adr_calc;

    function automatic logic [CFG_W-1:0] last_idx(input logic [CFG_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    function automatic logic [CFG_W-1:0] at_least_one(input logic [CFG_W-1:0] v);
        return (v == '0) ? CFG_W'(1) : v;
    endfunction

    // Configuration fields, MSB first
    assign ox0_c    = cfg_q[9*CFG_W +: CFG_W];
    assign oy0_c    = cfg_q[8*CFG_W +: CFG_W];
    assign fx_c     = cfg_q[7*CFG_W +: CFG_W];
    assign fy_c     = cfg_q[6*CFG_W +: CFG_W];
    assign stride_c = cfg_q[5*CFG_W +: CFG_W];
    assign dil_c    = cfg_q[4*CFG_W +: CFG_W];
    assign pad_c    = cfg_q[3*CFG_W +: CFG_W];
    assign ix0_c    = cfg_q[2*CFG_W +: CFG_W];
    assign iy0_c    = cfg_q[1*CFG_W +: CFG_W];
    assign ic1_c    = cfg_q[0*CFG_W +: CFG_W];

    assign ox_last  = last_idx(ox0_c);
    assign oy_last  = last_idx(oy0_c);
    assign fx_last  = last_idx(fx_c);
    assign fy_last  = last_idx(fy_c);
    assign ic_last  = last_idx(ic1_c);
    assign stride_e = at_least_one(stride_c);
    assign dil_e    = at_least_one(dil_c);

    assign last_elem = (ox_q == ox_last) && (oy_q == oy_last) && (fx_q == fx_last) &&
                       (fy_q == fy_last) && (ic_q == ic_last);

    // XW bits hold the full signed range of x/y, so the modular subtraction yields two's complement
    always_comb begin
        x_u = XW'(ox_q) * XW'(stride_e) + XW'(fx_q) * XW'(dil_e) - XW'(pad_c);
        y_u = XW'(oy_q) * XW'(stride_e) + XW'(fy_q) * XW'(dil_e) - XW'(pad_c);
        // A negative value reads as a huge unsigned value, so the >= test also catches x<0 / y<0
        is_pad = x_u[XW-1] || y_u[XW-1] || (x_u >= XW'(ix0_c)) || (y_u >= XW'(iy0_c));
        // Low AW bits of each product depend only on the low AW bits of the operands
        adr_calc = AW'(x_u) + AW'(y_u) * AW'(ix0_c) + AW'(ic_q) * AW'(ix0_c) * AW'(iy0_c);
    end

    assign adr_if.adr_valid = (state_q == RUN);
    assign adr_if.adr_pad   = (state_q == RUN) && is_pad;
    assign adr_if.adr       = ((state_q == RUN) && !is_pad) ? adr_calc : '0;
    assign busy             = (state_q == RUN);
    assign done             = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            ic_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            ic_q    <= ic_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        ic_d    = ic_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (config_en) begin
                    cfg_d = config_data;
                end
                if (start) begin
                    state_d = RUN;
                    ox_d    = '0;
                    oy_d    = '0;
                    fx_d    = '0;
                    fy_d    = '0;
                    ic_d    = '0;
                end
            end
            RUN: begin
                if (adr_if.adr_ready) begin
                    // Nested wrap-and-carry; the final element wraps every counter back to 0
                    if (ox_q == ox_last) begin
                        ox_d = '0;
                        if (oy_q == oy_last) begin
                            oy_d = '0;
                            if (fx_q == fx_last) begin
                                fx_d = '0;
                                if (fy_q == fy_last) begin
                                    fy_d = '0;
                                    if (ic_q == ic_last) begin
                                        ic_d = '0;
                                    end else begin
                                        ic_d = ic_q + 1'b1;
                                    end
                                end else begin
                                    fy_d = fy_q + 1'b1;
                                end
                            end else begin
                                fx_d = fx_q + 1'b1;
                            end
                        end else begin
                            oy_d = oy_q + 1'b1;
                        end
                    end else begin
                        ox_d = ox_q + 1'b1;
                    end
                    if (last_elem) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
